gpu_task_sched: RTL and testbench
=================================

GPU_TASK_SCHED -- requirements
Module: gpu_task_sched

Parameters
REQ-001 NUM_CORES, default 4, number of gpu_core instances served (1..16).
REQ-002 KERNEL_LEN, fixed 16, instructions per kernel, equal to core instruction memory depth.

Interface
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low; asserted at 0.
REQ-005 host_we  input  1  write strobe into kernel buffer.
REQ-006 host_addr  input  4  kernel buffer slot.
REQ-007 host_wdata  input  16  instruction word.
REQ-008 host_start  input  1  single-cycle launch pulse.
REQ-009 core_mask  input  NUM_CORES  cores to launch, sampled with host_start.
REQ-010 busy  output  1  high from accepted launch until done.
REQ-011 done  output  1  one-cycle pulse when all launched cores report ready.
REQ-012 host_err  output  1  one-cycle pulse on write or start rejected while busy.
REQ-013 instruction  output  16  instruction broadcast to all cores.
REQ-014 val_ins  output  NUM_CORES  one-hot per-core instruction valid.
REQ-015 rtr  input  NUM_CORES  per-core ready-to-receive.
REQ-016 ready  input  NUM_CORES  per-core kernel-complete flag.

Function
REQ-017 Kernel buffer: 16x16; host_we with busy=0 writes host_wdata to host_addr at the clock edge; contents persist across launches.
REQ-018 FSM states: IDLE, SEL, WAIT_RTR, STREAM, WAIT_DONE, FIN.
REQ-019 IDLE: host_start with busy=0 latches core_mask into launch_mask, clears pending_mask, sets busy, moves to SEL.
REQ-020 SEL: pick lowest-index set bit of launch_mask as cur_core, clear that bit, go to WAIT_RTR; if launch_mask is empty, go to WAIT_DONE.
REQ-021 WAIT_RTR: stay until rtr[cur_core]=1, then go to STREAM with beat=0.
REQ-022 STREAM: each cycle drive instruction=buffer[beat] and val_ins[cur_core]=1, all other val_ins bits 0; increment beat; exactly 16 consecutive beats, no gaps.
REQ-023 On beat 15: set pending_mask[cur_core], go to SEL; val_ins is 0 in the following cycle.
REQ-024 rtr is not re-checked during STREAM; a core that asserted rtr accepts all 16 beats.
REQ-025 pending_mask[k] clears in any cycle where pending_mask[k]=1, ready[k]=1 and core k is not currently streaming; the check is active in SEL, WAIT_RTR, STREAM and WAIT_DONE.
REQ-026 WAIT_DONE: when pending_mask=0, go to FIN.
REQ-027 FIN: pulse done=1 for one cycle, clear busy, return to IDLE.
REQ-028 core_mask=0 at start: done pulses 3 cycles after host_start (SEL, WAIT_DONE, FIN).
REQ-029 Bits of core_mask at or above NUM_CORES are ignored.
REQ-030 host_start or host_we while busy=1: ignored, host_err pulses one cycle, buffer unchanged.
REQ-031 host_we and host_start in the same cycle in IDLE: the write completes first; the launch streams the new word.
REQ-032 Latency for one core with rtr already high: first val_ins 3 cycles after host_start; last beat at cycle 18.
REQ-033 instruction holds its last driven value when val_ins=0; consumers qualify it by val_ins.

Reset
REQ-034 reset=0 forces IDLE immediately, including mid-STREAM; a partially streamed core is not recovered by this block.
REQ-035 Reset values: busy=0, done=0, host_err=0, val_ins=0, instruction=0, launch_mask=0, pending_mask=0, beat=0, cur_core=0.
REQ-036 The kernel buffer is not cleared by reset.

Structure
REQ-037 Shared package gpu_pkg holds: KERNEL_LEN, INSTR_W=16, opcode width/values, and the scheduler state enumeration.
REQ-038 One sub-module, ts_kernel_buf: 16x16 buffer with one synchronous write port and one combinational read port; all other logic lives in the top.

Verification
REQ-039 Load 16 words 0x1000+i, launch core_mask=0001 with rtr=1 -> val_ins[0] high cycles 3..18, instruction=0x1000..0x100F in order, busy=1.
REQ-040 core_mask=0101, rtr[2] held low 10 cycles -> core0 streams first; core2 streams only after rtr[2] rises; no val_ins to cores 1 or 3.
REQ-041 After REQ-040, raise ready[2] then ready[0] -> done pulses exactly once, 2 cycles after the later ready; busy falls with it.
REQ-042 host_we and host_start pulsed during STREAM -> host_err pulses each time; buffer unchanged; stream unaffected.
REQ-043 core_mask=0000 -> no val_ins; done pulses at cycle 3.
REQ-044 reset low at beat 7 -> val_ins=0 and busy=0 asynchronously; a new launch after release streams from beat 0.

Source files
------------

// File: rtl/gpu_pkg.sv
// gpu_pkg: shared kernel geometry, opcode encodings and scheduler state type.
package gpu_pkg;
    localparam int KERNEL_LEN = 16;
    localparam int INSTR_W    = 16;
    localparam int OPCODE_W   = 4;
    localparam logic [OPCODE_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OPCODE_W-1:0] OP_ADD  = 4'h1;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 4'h2;
    localparam logic [OPCODE_W-1:0] OP_MUL  = 4'h3;
    localparam logic [OPCODE_W-1:0] OP_LD   = 4'h4;
    localparam logic [OPCODE_W-1:0] OP_ST   = 4'h5;
    localparam logic [OPCODE_W-1:0] OP_BR   = 4'h6;
    localparam logic [OPCODE_W-1:0] OP_HALT = 4'hF;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEL,
        ST_WAIT_RTR,
        ST_STREAM,
        ST_WAIT_DONE,
        ST_FIN
    } sched_state_t;
    function automatic logic [3:0] lowest_set(input logic [15:0] m);
        lowest_set = '0;
        for (int i = 15; i >= 0; i--) if (m[i]) lowest_set = 4'(i);
    endfunction
endpackage

// File: rtl/gpu_task_sched_if.sv
// gpu_task_sched_if: host launch port plus the per-core instruction broadcast bus.
interface gpu_task_sched_if import gpu_pkg::*; #(parameter int NUM_CORES = 4);
    logic                 host_we;
    logic [3:0]           host_addr;
    logic [INSTR_W-1:0]   host_wdata;
    logic                 host_start;
    logic [NUM_CORES-1:0] core_mask;
    logic                 busy;
    logic                 done;
    logic                 host_err;
    logic [INSTR_W-1:0]   instruction;
    logic [NUM_CORES-1:0] val_ins;
    logic [NUM_CORES-1:0] rtr;
    logic [NUM_CORES-1:0] ready;
    modport master (
        output host_we, host_addr, host_wdata, host_start, core_mask, rtr, ready,
        input  busy, done, host_err, instruction, val_ins
    );
    modport slave (
        input  host_we, host_addr, host_wdata, host_start, core_mask, rtr, ready,
        output busy, done, host_err, instruction, val_ins
    );
endinterface

// File: rtl/ts_kernel_buf.sv
// ts_kernel_buf: 16x16 kernel store, synchronous write, combinational read, never reset.
module ts_kernel_buf import gpu_pkg::*; (
    input  logic               clk,
    input  logic               we,
    input  logic [3:0]         waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic [3:0]         raddr,
    output logic [INSTR_W-1:0] rdata
);
    logic [INSTR_W-1:0] mem [KERNEL_LEN];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/gpu_task_sched.sv
// gpu_task_sched: streams the kernel buffer to each masked core in index order,
// then waits until every launched core reports ready before pulsing done.
module gpu_task_sched import gpu_pkg::*; #(parameter int NUM_CORES = 4) (
    input logic             clk,
    input logic             reset,
    gpu_task_sched_if.slave bus
);
    sched_state_t         state, state_d;
    logic [15:0]          launch_mask, launch_mask_d;
    logic [NUM_CORES-1:0] pending_mask, pending_mask_d;
    logic [NUM_CORES-1:0] core_sel;
    logic [3:0]           cur_core, cur_core_d;
    logic [3:0]           beat, beat_d;
    logic [INSTR_W-1:0]   rd_data, last_instr;
    logic [15:0]          rtr_w;
    logic                 busy, streaming, last_beat;
    ts_kernel_buf u_buf (
        .clk   (clk),
        .we    (bus.host_we && !busy),
        .waddr (bus.host_addr),
        .wdata (bus.host_wdata),
        .raddr (beat),
        .rdata (rd_data)
    );
    assign busy      = state != ST_IDLE && state != ST_FIN;
    assign streaming = state == ST_STREAM;
    assign last_beat = streaming && beat == 4'(KERNEL_LEN - 1);
    assign rtr_w     = 16'(bus.rtr);
    assign core_sel  = streaming ? NUM_CORES'(1) << cur_core : '0;
    assign bus.busy        = busy;
    assign bus.done        = state == ST_FIN;
    assign bus.host_err    = busy && (bus.host_we || bus.host_start);
    assign bus.val_ins     = core_sel;
    assign bus.instruction = streaming ? rd_data : last_instr;
    always_comb begin
        state_d        = state;
        launch_mask_d  = launch_mask;
        cur_core_d     = cur_core;
        beat_d         = beat;
        // ready only retires a core once it is no longer being fed
        pending_mask_d = busy ? (pending_mask & ~(bus.ready & ~core_sel)) | (last_beat ? core_sel : '0)
                              : pending_mask;
        case (state)
            ST_IDLE, ST_FIN: begin
                state_d = ST_IDLE;
                if (bus.host_start) begin
                    state_d        = ST_SEL;
                    launch_mask_d  = 16'(bus.core_mask);
                    pending_mask_d = '0;
                end
            end
            ST_SEL: begin
                if (launch_mask == '0) state_d = ST_WAIT_DONE;
                else begin
                    cur_core_d    = lowest_set(launch_mask);
                    launch_mask_d = launch_mask & ~(16'(1) << cur_core_d);
                    state_d       = ST_WAIT_RTR;
                end
            end
            ST_WAIT_RTR: begin
                if (rtr_w[cur_core]) begin
                    state_d = ST_STREAM;
                    beat_d  = '0;
                end
            end
            ST_STREAM: begin
                beat_d = beat + 4'd1;
                if (last_beat) state_d = ST_SEL;
            end
            ST_WAIT_DONE: if (pending_mask == '0) state_d = ST_FIN;
            default: state_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state        <= ST_IDLE;
            launch_mask  <= '0;
            pending_mask <= '0;
            cur_core     <= '0;
            beat         <= '0;
            last_instr   <= '0;
        end else begin
            state        <= state_d;
            launch_mask  <= launch_mask_d;
            pending_mask <= pending_mask_d;
            cur_core     <= cur_core_d;
            beat         <= beat_d;
            last_instr   <= streaming ? rd_data : last_instr;
        end
endmodule

// File: tb/tb_gpu_task_sched.sv
// tb_gpu_task_sched: directed launch scenarios with hand-computed cycle expectations.
module tb_gpu_task_sched;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [3:0] exp_v;
    always #5 clk = ~clk;
    gpu_task_sched_if #(.NUM_CORES(4)) bus ();
    gpu_task_sched #(.NUM_CORES(4)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask
    initial begin
        bus.host_we = 0; bus.host_addr = '0; bus.host_wdata = '0;
        bus.host_start = 0; bus.core_mask = '0; bus.rtr = '0; bus.ready = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst busy", bus.busy, 0);
        check("rst done", bus.done, 0);
        check("rst host_err", bus.host_err, 0);
        check("rst val_ins", bus.val_ins, 0);
        check("rst instruction", bus.instruction, 0);
        @(negedge clk) reset = 1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            bus.host_we = 1; bus.host_addr = 4'(i); bus.host_wdata = 16'(16'h1000 + i);
        end
        @(negedge clk) bus.host_we = 0;
        // single core, rtr already high
        bus.rtr = 4'b1111;
        @(negedge clk) begin bus.host_start = 1; bus.core_mask = 4'b0001; end
        for (int c = 1; c <= 23; c++) begin
            @(negedge clk);
            bus.host_start = 0;
            if (c == 21) bus.ready = 4'b0001;
            #1;
            check($sformatf("t1 val_ins c%0d", c), bus.val_ins, (c >= 3 && c <= 18) ? 1 : 0);
            if (c >= 3) check($sformatf("t1 instr c%0d", c), bus.instruction, c <= 18 ? 16'h1000 + c - 3 : 16'h100F);
            check($sformatf("t1 busy c%0d", c), bus.busy, c < 23);
            check($sformatf("t1 done c%0d", c), bus.done, c == 23);
        end
        bus.ready = '0;
        // two cores, core2 stalls on rtr, then staggered ready
        bus.rtr = 4'b1011;
        @(negedge clk) begin bus.host_start = 1; bus.core_mask = 4'b0101; end
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            bus.host_start = 0;
            if (c == 24) bus.rtr = 4'b1111;
            if (c == 43) bus.ready = 4'b0100;
            if (c == 46) bus.ready = 4'b0101;
            #1;
            exp_v = (c >= 3 && c <= 18) ? 4'b0001 : (c >= 25 && c <= 40) ? 4'b0100 : 4'b0000;
            check($sformatf("t2 val_ins c%0d", c), bus.val_ins, exp_v);
            if (c >= 25 && c <= 40) check($sformatf("t2 instr c%0d", c), bus.instruction, 16'h1000 + c - 25);
            check($sformatf("t2 done c%0d", c), bus.done, c == 48);
            check($sformatf("t2 busy c%0d", c), bus.busy, c < 48);
        end
        bus.ready = '0;
        // host traffic while streaming is rejected
        @(negedge clk) begin bus.host_start = 1; bus.core_mask = 4'b0010; end
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            bus.host_start = 0; bus.host_we = 0;
            if (c == 5) begin bus.host_we = 1; bus.host_addr = 4'd3; bus.host_wdata = 16'hDEAD; end
            if (c == 8) begin bus.host_start = 1; bus.core_mask = 4'b1111; end
            if (c == 21) bus.ready = 4'b0010;
            #1;
            check($sformatf("t3 host_err c%0d", c), bus.host_err, c == 5 || c == 8);
            check($sformatf("t3 val_ins c%0d", c), bus.val_ins, (c >= 3 && c <= 18) ? 4'b0010 : 4'b0000);
            if (c >= 3 && c <= 18) check($sformatf("t3 instr c%0d", c), bus.instruction, 16'h1000 + c - 3);
            check($sformatf("t3 done c%0d", c), bus.done, c == 23);
        end
        bus.ready = '0;
        // empty mask
        @(negedge clk) begin bus.host_start = 1; bus.core_mask = 4'b0000; end
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            bus.host_start = 0;
            #1;
            check($sformatf("t4 val_ins c%0d", c), bus.val_ins, 0);
            check($sformatf("t4 done c%0d", c), bus.done, c == 3);
            check($sformatf("t4 busy c%0d", c), bus.busy, c == 1 || c == 2);
        end
        // reset mid-stream at beat 7
        @(negedge clk) begin bus.host_start = 1; bus.core_mask = 4'b0001; end
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            bus.host_start = 0;
            #1;
            check($sformatf("t5 val_ins c%0d", c), bus.val_ins, c >= 3 ? 1 : 0);
        end
        @(negedge clk) reset = 0;
        #1;
        check("t5 async val_ins", bus.val_ins, 0);
        check("t5 async busy", bus.busy, 0);
        check("t5 async instruction", bus.instruction, 0);
        @(negedge clk) reset = 1;
        // same-cycle write and launch: beat 0 carries the new word
        @(negedge clk) begin
            bus.host_we = 1; bus.host_addr = 4'd0; bus.host_wdata = 16'hBEEF;
            bus.host_start = 1; bus.core_mask = 4'b0001;
        end
        #1;
        check("t6 host_err", bus.host_err, 0);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            bus.host_start = 0; bus.host_we = 0;
            #1;
            check($sformatf("t6 val_ins c%0d", c), bus.val_ins, c >= 3 ? 1 : 0);
            if (c >= 3) check($sformatf("t6 instr c%0d", c), bus.instruction, c == 3 ? 16'hBEEF : 16'h1000 + c - 3);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
